src_port_arbiter: RTL and testbench

- Shares one NoC router injection port between NUM_REQ traffic sources.
- Each source uses the codebase's ready-then-valid injection protocol: ready high at cycle t, flit valid at t+1.
- Grants one source per cycle using weighted round-robin (BURST grants per turn).
- Buffers accepted flits in a small FIFO and re-issues them to the router under the same protocol.
- Sits between the per-node src generators and the router port.

---
 rtl/lynx_noc_pkg.sv | 13 +
 rtl/src_arb_fifo.sv | 37 +++
 rtl/src_port_arbiter.sv | 96 +++++++++
 tb/tb_src_port_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/lynx_noc_pkg.sv
// lynx_noc_pkg: shared NoC widths and the flit record carried between sources and routers.
package lynx_noc_pkg;
  localparam int LYNX_WIDTH = 32;
  localparam int LYNX_N = 16;
  localparam int LYNX_NUM_VC = 2;
  localparam int LYNX_N_ADDR_WIDTH = $clog2(LYNX_N);
  localparam int LYNX_VC_ADDR_WIDTH = $clog2(LYNX_NUM_VC);
  typedef struct packed {
    logic [LYNX_WIDTH-1:0] data;
    logic [LYNX_N_ADDR_WIDTH-1:0] dest;
    logic [LYNX_VC_ADDR_WIDTH-1:0] vc;
  } flit_t;
endpackage

// File: rtl/src_arb_fifo.sv
// src_arb_fifo: small synchronous flit FIFO with occupancy count and asynchronous active-low reset.
module src_arb_fifo
  import lynx_noc_pkg::*;
#(
  parameter type T = flit_t,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  T din,
  output T dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW:0] wr, rd;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push && !full) wr <= wr + 1'b1;
      if (pop && !empty) rd <= rd + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr[AW-1:0]] <= din;
  end
  assign count = wr - rd;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd[AW-1:0]];
endmodule

// File: rtl/src_port_arbiter.sv
// src_port_arbiter: weighted round-robin sharing of one router injection port; granted
// flits are buffered and re-issued under the ready-then-valid protocol.
module src_port_arbiter
  import lynx_noc_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = LYNX_WIDTH,
  parameter int N = LYNX_N,
  parameter int NUM_VC = LYNX_NUM_VC,
  parameter int N_ADDR_WIDTH = $clog2(N),
  parameter int VC_ADDR_WIDTH = $clog2(NUM_VC),
  parameter int FIFO_DEPTH = 4,
  parameter int BURST = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_REQ-1:0] req_in,
  output logic [NUM_REQ-1:0] ready_out,
  input  logic [NUM_REQ-1:0] valid_in,
  input  logic [NUM_REQ*WIDTH-1:0] data_in,
  input  logic [NUM_REQ*N_ADDR_WIDTH-1:0] dest_in,
  input  logic [NUM_REQ*VC_ADDR_WIDTH-1:0] vc_in,
  output logic [WIDTH-1:0] data_out,
  output logic [N_ADDR_WIDTH-1:0] dest_out,
  output logic [VC_ADDR_WIDTH-1:0] vc_out,
  output logic valid_out,
  input  logic ready_in,
  output logic err
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(FIFO_DEPTH);
  localparam int OW = CW + 2;
  localparam int BW = $clog2(BURST + 1);
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [N_ADDR_WIDTH-1:0] dest;
    logic [VC_ADDR_WIDTH-1:0] vc;
  } flit_p_t;
  flit_p_t src [NUM_REQ];
  flit_p_t head;
  logic [IW-1:0] last, cap_idx, nxt, cand, gsel;
  logic [BW-1:0] bcnt;
  logic [CW:0] count;
  logic [OW-1:0] occ;
  logic inflight, stay, grant, push, pop, full, empty;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_src
    assign src[i] = {data_in[i*WIDTH +: WIDTH], dest_in[i*N_ADDR_WIDTH +: N_ADDR_WIDTH],
                     vc_in[i*VC_ADDR_WIDTH +: VC_ADDR_WIDTH]};
  end
  // Scan downward so the nearest requester after the last grant wins.
  always_comb begin
    nxt = last;
    cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % NUM_REQ);
      if (req_in[cand]) nxt = cand;
    end
  end
  assign stay = req_in[last] && bcnt != '0 && bcnt < BW'(BURST);
  assign gsel = stay ? last : nxt;
  // Credit counts the grant on the wire and the flit being captured; pops are not credited.
  assign occ = OW'(count) + OW'(|ready_out) + OW'(inflight);
  assign grant = |req_in && occ < OW'(FIFO_DEPTH);
  assign push = inflight && valid_in[cap_idx] && !full;
  assign pop = ready_in && !empty;
  src_arb_fifo #(.T(flit_p_t), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(src[cap_idx]), .dout(head),
    .full(full), .empty(empty), .count(count)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_out <= '0;
      last <= IW'(NUM_REQ - 1);
      bcnt <= '0;
      inflight <= 1'b0;
      cap_idx <= '0;
      err <= 1'b0;
      valid_out <= 1'b0;
      data_out <= '0;
      dest_out <= '0;
      vc_out <= '0;
    end else begin
      ready_out <= '0;
      inflight <= |ready_out;
      cap_idx <= last;
      valid_out <= pop;
      if (inflight && !valid_in[cap_idx]) err <= 1'b1;
      if (pop) {data_out, dest_out, vc_out} <= head;
      if (grant) begin
        ready_out <= NUM_REQ'(1) << gsel;
        last <= gsel;
        bcnt <= stay ? bcnt + 1'b1 : BW'(1);
      end
    end
  end
endmodule

// File: tb/tb_src_port_arbiter.sv
// tb_src_port_arbiter: random and directed traffic into BURST=1 and BURST=2 arbiters,
// checked every cycle against a queue-based reference model and a few literal sequences.
module tb_src_port_arbiter;
  localparam int NR = 4, W = 32, NA = 4, VA = 1, D = 4, FW = W + NA + VA;
  logic clk = 1'b0, rst = 1'b0, rin = 1'b0;
  logic [NR-1:0] req = '0;
  logic [NR-1:0] rdy_o [2];
  logic [NR-1:0] vin [2];
  logic [NR*W-1:0] din [2];
  logic [NR*NA-1:0] dsti [2];
  logic [NR*VA-1:0] vci [2];
  logic [W-1:0] dout [2];
  logic [NA-1:0] dsto [2];
  logic [VA-1:0] vco [2];
  logic [1:0] vout, erro;
  int last_m [2], bcnt_m [2], gr [2], cap [2];
  bit ev [2], eerr [2];
  logic [FW-1:0] eout [2];
  logic [FW-1:0] mq [2][$];
  int glog [2][$];
  int cnt [2][NR];
  logic [NR-1:0] prev [2];
  bit drop_once [2];
  int n_chk = 0, n_fail = 0, p_drop = 0, p_spur = 0, exp3 = -1, n3 = 0;
  bit chk3 = 1'b0;
  int rr0 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int rr1 [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
  int bs1 [6] = '{0, 0, 2, 2, 0, 0};

  always #5 clk = ~clk;

  for (genvar m = 0; m < 2; m++) begin : g_dut
    src_port_arbiter #(.BURST(m + 1)) dut (
      .clk(clk), .rst(rst), .req_in(req), .ready_out(rdy_o[m]), .valid_in(vin[m]),
      .data_in(din[m]), .dest_in(dsti[m]), .vc_in(vci[m]), .data_out(dout[m]),
      .dest_out(dsto[m]), .vc_out(vco[m]), .valid_out(vout[m]), .ready_in(rin), .err(erro[m])
    );
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int gat(int m, int k);
    return k < glog[m].size() ? glog[m][k] : -1;
  endfunction

  function automatic void model_reset(int m);
    last_m[m] = NR - 1;
    bcnt_m[m] = 0;
    gr[m] = -1;
    cap[m] = -1;
    mq[m].delete();
    ev[m] = 1'b0;
    eout[m] = '0;
    eerr[m] = 1'b0;
  endfunction

  // One clock of the reference: pop, then capture (no bypass), then the next grant.
  function automatic void model_edge(int m);
    int occ, g;
    occ = mq[m].size() + int'(gr[m] >= 0) + int'(cap[m] >= 0);
    ev[m] = rin && mq[m].size() > 0;
    if (ev[m]) eout[m] = mq[m].pop_front();
    if (cap[m] >= 0) begin
      if (vin[m][cap[m]])
        mq[m].push_back({din[m][cap[m]*W +: W], dsti[m][cap[m]*NA +: NA], vci[m][cap[m]*VA +: VA]});
      else eerr[m] = 1'b1;
    end
    cap[m] = gr[m];
    g = -1;
    if (req != '0 && occ < D) begin
      if (bcnt_m[m] > 0 && bcnt_m[m] < m + 1 && req[last_m[m]]) begin
        g = last_m[m];
        bcnt_m[m]++;
      end else begin
        for (int k = 1; k <= NR && g < 0; k++) if (req[(last_m[m] + k) % NR]) g = (last_m[m] + k) % NR;
        bcnt_m[m] = 1;
      end
      last_m[m] = g;
    end
    gr[m] = g;
  endfunction

  initial begin
    for (int m = 0; m < 2; m++) model_reset(m);
    forever begin
      @(posedge clk);
      for (int m = 0; m < 2; m++) if (!rst) model_reset(m); else model_edge(m);
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (!rst) model_reset(m);
        chk($sformatf("ready_out[%0d]", m), rdy_o[m], gr[m] >= 0 ? 64'(1) << gr[m] : 64'(0));
        chk($sformatf("valid_out[%0d]", m), vout[m], 64'(ev[m]));
        chk($sformatf("flit_out[%0d]", m), {dout[m], dsto[m], vco[m]}, eout[m]);
        chk($sformatf("err[%0d]", m), erro[m], 64'(eerr[m]));
        for (int i = 0; i < NR; i++) if (rdy_o[m][i]) glog[m].push_back(i);
      end
      if (chk3 && vout[0] && dout[0][31:24] == 8'd3) begin
        if (exp3 >= 0) chk("src3_seq", dout[0][23:0], exp3);
        exp3 = int'(dout[0][23:0]) + 1;
        n3++;
      end
    end
  end

  // Sources answer a grant seen last cycle with a counted flit; extras are noise.
  task automatic step();
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < NR; i++) begin
        bit v;
        v = prev[m][i];
        if (v && drop_once[m] && i == 1) begin
          v = 1'b0;
          drop_once[m] = 1'b0;
        end
        if (v && $urandom_range(99) < p_drop) v = 1'b0;
        din[m][i*W +: W] = $urandom;
        if (v) begin
          din[m][i*W +: W] = {8'(i), 24'(cnt[m][i])};
          cnt[m][i]++;
        end else if ($urandom_range(99) < p_spur) v = 1'b1;
        vin[m][i] = v;
        dsti[m][i*NA +: NA] = 4'($urandom);
        vci[m][i*VA +: VA] = 1'($urandom);
      end
      prev[m] = rdy_o[m];
    end
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    step();
    rst = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rst_ready[%0d]", m), rdy_o[m], 0);
      chk($sformatf("rst_valid[%0d]", m), vout[m], 0);
      chk($sformatf("rst_err[%0d]", m), erro[m], 0);
    end
    step();
    rst = 1'b1;
    glog[0].delete();
    glog[1].delete();
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      vin[m] = '0; din[m] = '0; dsti[m] = '0; vci[m] = '0; prev[m] = '0; drop_once[m] = 1'b0;
      for (int i = 0; i < NR; i++) cnt[m][i] = 0;
    end
    run(3);
    rst = 1'b1;
    req = '1;
    rin = 1'b1;
    run(10);
    do_reset();
    for (int s = 0; s < 12; s++) begin
      step();
      if (s >= 6) chk("rr_stream", vout[0], 1);
    end
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rr_b1[%0d]", k), gat(0, k), rr0[k]);
      chk($sformatf("rr_b2[%0d]", k), gat(1, k), rr1[k]);
    end
    rin = 1'b0;
    do_reset();
    run(12);
    chk("bp_grants_b1", glog[0].size(), 4);
    chk("bp_grants_b2", glog[1].size(), 4);
    rin = 1'b1;
    run(20);
    chk("bp_resume", glog[0].size() > 4, 1);
    req = 4'b0101;
    do_reset();
    run(8);
    for (int k = 0; k < 6; k++) chk($sformatf("burst_b2[%0d]", k), gat(1, k), bs1[k]);
    for (int k = 0; k < 4; k++) chk($sformatf("burst_b1[%0d]", k), gat(0, k), k % 2 ? 2 : 0);
    do_reset();
    for (int s = 0; s < 10; s++) begin
      step();
      if (rdy_o[1][0]) break;
    end
    req = 4'b0100;
    run(4);
    chk("burst_drop_first", gat(1, 0), 0);
    chk("burst_drop_next", gat(1, 1), 2);
    req = 4'b1000;
    do_reset();
    chk3 = 1'b1;
    exp3 = -1;
    n3 = 0;
    run(110);
    chk3 = 1'b0;
    chk("single_count", n3 >= 100, 1);
    chk("single_src", gat(0, 50), 3);
    req = 4'b0010;
    do_reset();
    drop_once[0] = 1'b1;
    drop_once[1] = 1'b1;
    run(6);
    chk("err_set_b1", erro[0], 1);
    chk("err_set_b2", erro[1], 1);
    req = '0;
    run(5);
    chk("err_sticky", erro[0], 1);
    chk("err_next_grant", gat(0, 1), 1);
    p_drop = 3;
    p_spur = 20;
    for (int s = 0; s < 3000; s++) begin
      if (s % 600 == 0) do_reset();
      if ($urandom_range(99) < 20) req = $urandom_range(3) == 0 ? 4'hF : 4'($urandom);
      rin = $urandom_range(99) < 70;
      step();
    end
    run(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
